// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// architectural constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FULL  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0: the canonical RISC-V NOP shown in the IR after reset.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned PC_STEP = 4;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register that parks a returned instruction word and its
// PC while decode is back-pressuring the instruction register.
module fetch_hold_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  unload,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  full
);

    // NOTE: a single entry is just flops, so data and PC are reset along with
    // the full flag; deeper storage would leave the payload unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            pc   <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            pc   <= load_pc;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory and hands returned words to decode through the IR.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                   FETCH_Clk,
    input  logic                   FETCH_Reset,
    input  logic                   FETCH_Pc_Reset,
    input  logic                   FETCH_Enpc,
    input  logic                   FETCH_Ir_Enable,
    input  logic                   FETCH_Insmem_Read,
    input  logic                   FETCH_Redirect_Valid,
    input  logic [ADDR_WIDTH-1:0]  FETCH_Redirect_Pc,
    input  logic                   FETCH_Stall,
    output logic                   FETCH_Mem_Req,
    output logic [ADDR_WIDTH-1:0]  FETCH_Mem_Addr,
    input  logic                   FETCH_Mem_Rvalid,
    input  logic [INSTR_WIDTH-1:0] FETCH_Mem_Rdata,
    output logic [INSTR_WIDTH-1:0] FETCH_Ir,
    output logic [ADDR_WIDTH-1:0]  FETCH_Ir_Pc,
    output logic                   FETCH_Ir_Valid
);

    fetch_state_t            state;
    fetch_state_t            resume_state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [ADDR_WIDTH-1:0]   kill_pc;
    logic                    flush;

    logic                    go;
    logic                    consume;
    logic                    slot_free;
    logic                    load_ok;
    logic                    kill;

    logic                    hold_load;
    logic                    hold_unload;
    logic                    hold_release;
    logic                    hold_full;
    logic [INSTR_WIDTH-1:0]  hold_data;
    logic [ADDR_WIDTH-1:0]   hold_pc;

    assign go        = !FETCH_Pc_Reset && FETCH_Enpc && FETCH_Insmem_Read;
    assign consume   = FETCH_Ir_Valid && !FETCH_Stall;
    assign slot_free = !FETCH_Ir_Valid || consume;
    assign load_ok   = slot_free && FETCH_Ir_Enable;

    // Redirect and PC-reset share one kill path; redirect wins the target.
    assign kill    = FETCH_Redirect_Valid || FETCH_Pc_Reset;
    assign kill_pc = FETCH_Redirect_Valid ? (FETCH_Redirect_Pc & ~ADDR_WIDTH'(3)) : RESET_PC;

    assign pc_inc       = pc + ADDR_WIDTH'(PC_STEP);
    assign resume_state = go ? ST_ISSUE : ST_IDLE;

    assign hold_load    = (state == ST_WAIT) && FETCH_Mem_Rvalid && !flush && !kill && !load_ok;
    assign hold_release = (state == ST_FULL) && hold_full && load_ok;
    assign hold_unload  = kill || hold_release;

    assign FETCH_Mem_Addr = pc;

    fetch_hold_buf #(
        .DATA_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold_buf (
        .clk       (FETCH_Clk),
        .reset     (FETCH_Reset),
        .load      (hold_load),
        .unload    (hold_unload),
        .load_data (FETCH_Mem_Rdata),
        .load_pc   (pc),
        .data      (hold_data),
        .pc        (hold_pc),
        .full      (hold_full)
    );

    // NOTE: every state flop is written with <= so all branches see the
    // pre-edge values; later assignments in the block override the defaults.
    always_ff @(posedge FETCH_Clk) begin
        if (FETCH_Reset) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            flush          <= 1'b0;
            FETCH_Mem_Req  <= 1'b0;
            FETCH_Ir       <= INSTR_WIDTH'(NOP_INSTR);
            FETCH_Ir_Pc    <= RESET_PC;
            FETCH_Ir_Valid <= 1'b0;
        end else begin
            FETCH_Mem_Req <= 1'b0;
            if (consume) begin
                FETCH_Ir_Valid <= 1'b0;
            end

            if (kill) begin
                pc             <= kill_pc;
                FETCH_Ir_Valid <= 1'b0;
                case (state)
                    ST_ISSUE: begin
                        flush <= 1'b1;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (FETCH_Mem_Rvalid) begin
                            flush         <= 1'b0;
                            state         <= resume_state;
                            FETCH_Mem_Req <= go;
                        end else begin
                            flush <= 1'b1;
                        end
                    end
                    ST_FULL: begin
                        state         <= resume_state;
                        FETCH_Mem_Req <= go;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go && !flush) begin
                            state         <= ST_ISSUE;
                            FETCH_Mem_Req <= 1'b1;
                        end
                    end
                    ST_ISSUE: state <= ST_WAIT;
                    ST_WAIT: begin
                        if (FETCH_Mem_Rvalid) begin
                            if (flush) begin
                                flush         <= 1'b0;
                                state         <= resume_state;
                                FETCH_Mem_Req <= go;
                            end else if (load_ok) begin
                                FETCH_Ir       <= FETCH_Mem_Rdata;
                                FETCH_Ir_Pc    <= pc;
                                FETCH_Ir_Valid <= 1'b1;
                                pc             <= pc_inc;
                                state          <= resume_state;
                                FETCH_Mem_Req  <= go;
                            end else begin
                                state <= ST_FULL;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (hold_release) begin
                            FETCH_Ir       <= hold_data;
                            FETCH_Ir_Pc    <= hold_pc;
                            FETCH_Ir_Valid <= 1'b1;
                            pc             <= pc_inc;
                            state          <= resume_state;
                            FETCH_Mem_Req  <= go;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural instruction memory, a
// scoreboard of words decode should receive, and cycle-directed checks.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_reset;
    logic        enpc;
    logic        ir_enable;
    logic        insmem_read;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          resp_cycle = 0;
    logic        outstanding = 1'b0;
    logic        flushed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] exp_addr = RESET_PC;

    always #5 clk = ~clk;

    fetch_unit dut (
        .FETCH_Clk            (clk),
        .FETCH_Reset          (reset),
        .FETCH_Pc_Reset       (pc_reset),
        .FETCH_Enpc           (enpc),
        .FETCH_Ir_Enable      (ir_enable),
        .FETCH_Insmem_Read    (insmem_read),
        .FETCH_Redirect_Valid (redirect_valid),
        .FETCH_Redirect_Pc    (redirect_pc),
        .FETCH_Stall          (stall),
        .FETCH_Mem_Req        (mem_req),
        .FETCH_Mem_Addr       (mem_addr),
        .FETCH_Mem_Rvalid     (mem_rvalid),
        .FETCH_Mem_Rdata      (mem_rdata),
        .FETCH_Ir             (ir),
        .FETCH_Ir_Pc          (ir_pc),
        .FETCH_Ir_Valid       (ir_valid)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Called at the falling edge of cycle cyc once this cycle's inputs are set:
    // scores what the next rising edge will do, then steps one clock and
    // drives the memory response for the new cycle.
    task automatic cycle();
        exp_t e;
        logic kill;
        kill = redirect_valid || pc_reset;
        if (reset) begin
            sb_q.delete();
            outstanding = 1'b0;
            flushed     = 1'b0;
            exp_addr    = RESET_PC;
        end else begin
            if (ir_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    check("ir_unexpected", 32'(ir_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_ir_pc", ir_pc, e.pc);
                    check("sb_ir_data", ir, e.data);
                end
            end
            if (mem_rvalid) begin
                if (!flushed && !kill) begin
                    e.pc   = req_addr;
                    e.data = mem_rdata;
                    sb_q.push_back(e);
                    exp_addr = req_addr + 32'd4;
                end
                outstanding = 1'b0;
                flushed     = 1'b0;
            end
            if (mem_req) begin
                check("sb_req_addr", mem_addr, exp_addr);
                check("single_outstanding", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
                flushed     = 1'b0;
                req_addr    = mem_addr;
                resp_cycle  = cyc + lat;
            end
            if (kill) begin
                if (outstanding) flushed = 1'b1;
                sb_q.delete();
                exp_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : RESET_PC;
            end
        end
        @(negedge clk);
        cyc++;
        mem_rvalid = outstanding && (cyc == resp_cycle);
        mem_rdata  = mem_rvalid ? (req_addr + 32'h0000_00A0) : 32'hDEAD_BEEF;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        reset          = 1'b1;
        pc_reset       = 1'b0;
        enpc           = 1'b0;
        ir_enable      = 1'b1;
        insmem_read    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'hDEAD_BEEF;

        @(negedge clk);
        cycle();
        reset = 1'b0;
        enpc  = 1'b1;
        cyc   = 0;

        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_ir_pc", ir_pc, RESET_PC);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);

        // Streaming with a 1-cycle memory: one instruction every two cycles.
        cycle();
        check("go_req", 32'(mem_req), 32'd1);
        check("go_addr", mem_addr, 32'h0);
        cycle();
        check("wait_no_req", 32'(mem_req), 32'd0);
        cycle();
        check("c3_ir_valid", 32'(ir_valid), 32'd1);
        check("c3_ir_pc", ir_pc, 32'h0);
        check("c3_ir", ir, 32'hA0);
        check("c3_req", 32'(mem_req), 32'd1);
        check("c3_addr", mem_addr, 32'h4);
        cycle();
        check("c4_ir_valid", 32'(ir_valid), 32'd0);
        run(7);
        check("c11_ir_valid", 32'(ir_valid), 32'd1);
        check("c11_ir_pc", ir_pc, 32'h10);

        // Back-pressure: the response for 0x14 parks in the hold buffer.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_no_req", 32'(mem_req), 32'd0);
        end
        check("stall_ir_pc_kept", ir_pc, 32'h10);
        check("stall_ir_valid_kept", 32'(ir_valid), 32'd1);
        stall = 1'b0;
        cycle();
        check("unstall_ir_pc", ir_pc, 32'h14);
        check("unstall_ir", ir, 32'hB4);
        check("unstall_req", 32'(mem_req), 32'd1);
        check("unstall_addr", mem_addr, 32'h18);

        // Redirect while waiting on a 3-cycle memory.
        cycle();
        lat = 3;
        run(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        check("redir_ir_valid", 32'(ir_valid), 32'd0);
        check("redir_no_req", 32'(mem_req), 32'd0);
        cycle();
        check("redir_flush_no_req", 32'(mem_req), 32'd0);
        cycle();
        check("redir_flushed_ir_valid", 32'(ir_valid), 32'd0);
        check("redir_req", 32'(mem_req), 32'd1);
        check("redir_addr", mem_addr, 32'h100);

        // Redirect coincident with a response, with an unconsumed IR.
        run(4);
        check("c26_ir_pc", ir_pc, 32'h100);
        check("c26_ir", ir, 32'h1A0);
        stall = 1'b1;
        run(3);
        check("c29_rvalid_ir_valid", 32'(ir_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check("coinc_ir_valid", 32'(ir_valid), 32'd0);
        check("coinc_req", 32'(mem_req), 32'd1);
        check("coinc_addr", mem_addr, 32'h200);

        // PC-reset while a read is outstanding.
        run(4);
        check("c34_ir_pc", ir_pc, 32'h200);
        cycle();
        pc_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("pcrst_no_req", 32'(mem_req), 32'd0);
            check("pcrst_ir_valid", 32'(ir_valid), 32'd0);
        end
        check("pcrst_pc", mem_addr, RESET_PC);
        pc_reset = 1'b0;
        lat      = 1;
        cycle();
        check("pcrst_release_req", 32'(mem_req), 32'd1);
        check("pcrst_release_addr", mem_addr, RESET_PC);

        // Redirect during ISSUE to the top word, then PC wrap.
        run(2);
        check("c42_ir_pc", ir_pc, 32'h0);
        check("c42_addr", mem_addr, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("top_req", 32'(mem_req), 32'd1);
        check("top_addr", mem_addr, 32'hFFFF_FFFC);
        run(2);
        check("wrap_ir_pc", ir_pc, 32'hFFFF_FFFC);
        check("wrap_ir", ir, 32'h0000_009C);
        check("wrap_req", 32'(mem_req), 32'd1);
        check("wrap_addr", mem_addr, 32'h0);

        // Enable drops mid-WAIT: the read still lands, no new request.
        lat = 3;
        cycle();
        enpc = 1'b0;
        run(3);
        check("endrop_ir_valid", 32'(ir_valid), 32'd1);
        check("endrop_ir_pc", ir_pc, 32'h0);
        check("endrop_ir", ir, 32'hA0);
        check("endrop_no_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("endrop_idle_no_req", 32'(mem_req), 32'd0);
        end
        check("endrop_ir_consumed", 32'(ir_valid), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
